// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: time/cursor/status inputs and the
// multiplexed anode/cathode/decimal-point outputs.
interface seg_scan_driver_if;
   logic [35:0] time_i;
   logic [2:0]  curr_digit;
   logic        edit;
   logic        done;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output time_i, curr_digit, edit, done,
      input  an, seg, dp
   );

   modport slave (
      input  time_i, curr_digit, edit, done,
      output an, seg, dp
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner with per-frame time snapshot and edit blink.
// Optional macro DONE_FLASH_EN: flash the whole display while done=1.
module seg_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input logic            clk,
   input logic            rst,
   seg_scan_driver_if.slave bus
);

   localparam int unsigned SCAN_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BLINK_W = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

   typedef enum logic {
      ST_INIT,
      ST_SCAN
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_load_first;
   logic                w_scan_run;

   logic [SCAN_W-1:0]   r_scan_cnt;
   logic [2:0]          r_k;
   logic [35:0]         r_snap;
   logic [BLINK_W-1:0]  r_blink_cnt;
   logic                r_blink_phase;

   logic [7:0]          r_an;
   logic [6:0]          r_seg;
   logic                r_dp;

   logic                w_scan_wrap;
   logic                w_blink_wrap;
   logic [5:0]          w_nib_base;
   logic [3:0]          w_nib;
   logic [6:0]          w_seg;
   logic                w_edit_blank;
   logic                w_done_blank;

   // ST_INIT is the single post-reset cycle that captures time_i before any digit lights.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load_first = 1'b0;
      w_scan_run   = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_load_first = 1'b1;
            w_state_next = ST_SCAN;
         end
         ST_SCAN: begin
            w_scan_run   = 1'b1;
         end
         default: w_state_next = ST_INIT;
      endcase
   end

   assign w_scan_wrap  = (r_scan_cnt  == SCAN_W'(REFRESH_DIV - 1));
   assign w_blink_wrap = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_cnt <= '0;
         r_k        <= '0;
      end else if (w_scan_run) begin
         if (w_scan_wrap) begin
            r_scan_cnt <= '0;
            r_k        <= r_k + 3'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
         end
      end
   end

   // Snapshot only at frame boundaries so one frame never mixes two time values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snap <= '0;
      end else if (w_load_first || (w_scan_run && w_scan_wrap && (r_k == 3'd7))) begin
         r_snap <= bus.time_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
      end else if (w_blink_wrap) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= ~r_blink_phase;
      end else begin
         r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
      end
   end

   // ms1 occupies [3:0] and is skipped, so position k starts at bit 4k+4.
   assign w_nib_base = {1'b0, r_k, 2'b00} + 6'd4;
   assign w_nib      = r_snap[w_nib_base +: 4];

   always_comb begin
      w_seg = 7'h3F;
      case (w_nib)
         4'd0:    w_seg = 7'h40;
         4'd1:    w_seg = 7'h79;
         4'd2:    w_seg = 7'h24;
         4'd3:    w_seg = 7'h30;
         4'd4:    w_seg = 7'h19;
         4'd5:    w_seg = 7'h12;
         4'd6:    w_seg = 7'h02;
         4'd7:    w_seg = 7'h78;
         4'd8:    w_seg = 7'h00;
         4'd9:    w_seg = 7'h10;
         default: w_seg = 7'h3F;
      endcase
   end

   assign w_edit_blank = bus.edit && r_blink_phase && (bus.curr_digit <= 3'd5)
                         && (r_k == (3'd7 - bus.curr_digit));

`ifdef DONE_FLASH_EN
   assign w_done_blank = bus.done && r_blink_phase;
`else
   assign w_done_blank = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_an  <= 8'hFF;
         r_seg <= 7'h7F;
         r_dp  <= 1'b1;
      end else if (w_scan_run) begin
         r_an  <= (w_edit_blank || w_done_blank) ? 8'hFF : ~(8'h01 << r_k);
         r_seg <= w_seg;
         r_dp  <= ~((r_k == 3'd2) || (r_k == 3'd4) || (r_k == 3'd6));
      end
   end

   assign bus.an  = r_an;
   assign bus.seg = r_seg;
   assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4, BLINK_DIV=16 (32-cycle frame and blink period).
module tb_seg_scan_driver;

   localparam logic [35:0] TIME_A = 36'h123456780;
   localparam logic [35:0] TIME_B = 36'h095C59990;
   // Per-position cathode patterns, packed {k7,...,k0}.
   localparam logic [55:0] SEGS_A = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
   localparam logic [55:0] SEGS_B = {7'h40, 7'h10, 7'h12, 7'h3F, 7'h12, 7'h10, 7'h10, 7'h10};
`ifdef DONE_FLASH_EN
   localparam logic [31:0] MASK_DONE = 32'h7FFF_8000;
`else
   localparam logic [31:0] MASK_DONE = 32'h0000_0000;
`endif

   logic clk;
   logic rst;
   int unsigned n_cmp;
   int unsigned n_err;

   seg_scan_driver_if bus ();

   seg_scan_driver #(
      .REFRESH_DIV(4),
      .BLINK_DIV  (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One 32-cycle frame; mask bit c blanks the anodes on cycle c; time_i changes after cycle chg_at.
   task automatic run_frame(input string tag, input logic [55:0] segs, input logic [31:0] mask,
                            input int chg_at, input logic [35:0] chg_val);
      logic [7:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      for (int c = 0; c < 32; c++) begin
         int k;
         step();
         k       = c / 4;
         exp_an  = mask[c] ? 8'hFF : ~(8'h01 << k);
         exp_seg = segs[7*k +: 7];
         exp_dp  = (k == 2 || k == 4 || k == 6) ? 1'b0 : 1'b1;
         chk($sformatf("%s c%0d an", tag, c),  bus.an, exp_an);
         chk($sformatf("%s c%0d seg", tag, c), {1'b0, bus.seg}, {1'b0, exp_seg});
         chk($sformatf("%s c%0d dp", tag, c),  {7'd0, bus.dp}, {7'd0, exp_dp});
         if (c == chg_at) bus.time_i = chg_val;
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst            = 1'b1;
      bus.time_i     = TIME_A;
      bus.curr_digit = 3'd7;
      bus.edit       = 1'b0;
      bus.done       = 1'b0;

      #12;
      chk("reset an", bus.an, 8'hFF);
      chk("reset seg", {1'b0, bus.seg}, 8'h7F);
      chk("reset dp", {7'd0, bus.dp}, 8'h01);

      @(negedge clk);
      rst = 1'b0;
      step();
      chk("init an", bus.an, 8'hFF);
      chk("init seg", {1'b0, bus.seg}, 8'h7F);

      run_frame("f1", SEGS_A, 32'h0, 99, TIME_A);
      run_frame("tear", SEGS_A, 32'h0, 12, TIME_B);
      run_frame("newval", SEGS_B, 32'h0, 99, TIME_B);

      bus.edit = 1'b1;
      bus.curr_digit = 3'd2;
      run_frame("edit2", SEGS_B, 32'h00F0_0000, 99, TIME_B);
      bus.curr_digit = 3'd4;
      run_frame("edit4", SEGS_B, 32'h0000_8000, 99, TIME_B);
      bus.curr_digit = 3'd5;
      run_frame("edit5", SEGS_B, 32'h0, 99, TIME_B);
      bus.curr_digit = 3'd6;
      run_frame("edit6", SEGS_B, 32'h0, 99, TIME_B);
      bus.curr_digit = 3'd7;
      run_frame("edit7", SEGS_B, 32'h0, 99, TIME_B);

      bus.edit = 1'b0;
      bus.done = 1'b1;
      run_frame("done1", SEGS_B, MASK_DONE, 99, TIME_B);
      run_frame("done2", SEGS_B, MASK_DONE, 99, TIME_B);
      bus.done = 1'b0;

      // Abort mid-frame while position 5 is lit.
      for (int c = 0; c < 21; c++) step();
      chk("pre-rst an", bus.an, 8'hDF);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst an", bus.an, 8'hFF);
      chk("async rst seg", {1'b0, bus.seg}, 8'h7F);
      chk("async rst dp", {7'd0, bus.dp}, 8'h01);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step();
      chk("re-init an", bus.an, 8'hFF);
      run_frame("restart", SEGS_B, 32'h0, 99, TIME_B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clk cycles each digit stays lit.
REQ-002 Parameter BLINK_DIV, default 25000000, meaning clk cycles per blink-phase toggle.
REQ-003 Port clk, input, 1, meaning the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-005 Port time_i, input, 36, meaning BCD time {h2,h1,m2,m1,s2,s1,ms3,ms2,ms1}, 4 bits per digit, ms1 in [3:0].
REQ-006 Port curr_digit, input, 3, meaning edit cursor: 0=h2, 1=h1, 2=m2, 3=m1, 4=s2, 5=s1; 6 and 7 select no digit.
REQ-007 Port edit, input, 1, meaning the timer is in edit mode.
REQ-008 Port done, input, 1, meaning the countdown has expired.
REQ-009 Port an, output, 8, meaning anode enables, active-low, bit k drives display position k.
REQ-010 Port seg, output, 7, meaning cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 Port dp, output, 1, meaning decimal point, active-low.

Function
REQ-012 Scan counter: counts 0..REFRESH_DIV-1 and wraps; the digit index k (0..7) SHALL advance by 1 on each wrap, with 7 wrapping to 0.
REQ-013 Position k SHALL display time_snap[4k+7:4k+4]; ms1 is never displayed.
- k=0 ms2, k=1 ms3, k=2 s1, k=3 s2, k=4 m1, k=5 m2, k=6 h1, k=7 h2.
REQ-014 time_snap SHALL load from time_i in the same cycle that k advances from 7 to 0, so that a frame never mixes two time values.
REQ-015 an, seg and dp SHALL be registered; they SHALL reflect a new k exactly one clk cycle after k advances.
REQ-016 Exactly one an bit SHALL be low at a time, except when it is blanked per REQ-019/REQ-020.
REQ-017 Decode 0-9 to standard active-low patterns (0=7'h40, 1=7'h79, 8=7'h00, 9=7'h10); nibble values 10-15 SHALL display a dash (7'h3F).
REQ-018 dp SHALL be 0 (lit) at k=2, k=4 and k=6, and 1 otherwise.
REQ-019 Blink counter: counts 0..BLINK_DIV-1 and wraps; blink_phase SHALL toggle on each wrap.
- When edit=1, blink_phase=1, curr_digit<=5 and k==7-curr_digit, an SHALL be 8'hFF.
- When curr_digit is 6 or 7, no position blinks.
REQ-020 Simultaneous events: edit blanking and done flashing SHALL OR together; changes to edit or curr_digit SHALL take effect on the next registered output update.
REQ-021 The blink counter SHALL run continuously regardless of edit and done.

Reset
REQ-022 Assertion of rst SHALL immediately set: an=8'hFF, seg=7'h7F, dp=1, both counters=0, k=0, blink_phase=0, time_snap=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame.
- After release, scanning restarts at k=0.
- time_snap reloads from time_i on the first cycle after release.
- The first lit digit appears one cycle after that reload.

Configuration
REQ-024 Macro DONE_FLASH_EN, when defined: while done=1 and blink_phase=1, an SHALL be 8'hFF (whole-display flash).
REQ-025 Macro DONE_FLASH_EN, when not defined: done SHALL be ignored, and the display behaviour SHALL be identical to done=0.

Verification (REFRESH_DIV=4, BLINK_DIV=16)
REQ-026 Reset-release scenario: rst released, time_i=36'h12_3456_780 -> an sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles; seg for k=7 is 7'h79 ("1"); dp low only at FB, EF and BF.
REQ-027 Tearing scenario: time_i changes while k=3 -> positions 3..7 show the old value; the new value appears from the next k=0.
REQ-028 Invalid BCD scenario: time_i[23:20]=4'hC -> seg=7'h3F while an=EF.
REQ-029 Edit blink scenario: edit=1, curr_digit=2 -> an=FF during k=5 whenever blink_phase=1; curr_digit=6 -> no blanking.
REQ-030 Done flash scenario: done=1 -> with DONE_FLASH_EN, an=FF for 16-cycle windows alternating with normal scan; without DONE_FLASH_EN, normal scan.
REQ-031 Reset mid-operation scenario: rst pulsed at k=5 -> an=FF asynchronously; after release, the scan restarts at FE.
